// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding, fetch FSM states and
// default fetch-stage parameters.
package mips_pkg;

    localparam logic [31:0] NOP               = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam int unsigned DEFAULT_MEM_DEPTH = 32;

    typedef enum logic {
        RUN,
        HALT
    } fetch_state_t;

    // Byte address to instruction-memory word index.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register: synchronous reset, load, hold and +4 increment.
// Load beats hold so a redirect can break out of a stall or a halt.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (!hold) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS instruction-fetch stage: PC, instruction-memory addressing and IF/ID
// register. Define DELAY_SLOT_EN to keep the branch delay-slot instruction.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_DEPTH = DEFAULT_MEM_DEPTH
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] Read_address,
    input  logic [31:0] Instruction,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] Redirect_target,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PC_plus4,
    output logic        IFID_Valid,
    output logic        Halted
);

    localparam logic [31:0] DEPTH_WORDS = 32'(MEM_DEPTH);

    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_pc;
    logic         pc_in_range;
    logic         target_in_range;
    fetch_state_t state;

    assign redirect_pc     = {Redirect_target[31:2], 2'b00};
    assign pc_plus4        = pc + 32'd4;
    assign pc_in_range     = word_index(pc) < DEPTH_WORDS;
    assign target_in_range = word_index(Redirect_target) < DEPTH_WORDS;

    assign Read_address = word_index(pc);
    assign Halted       = (state == HALT) || !pc_in_range;

    // An out-of-range PC freezes until a redirect or reset moves it.
    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk       (Clk),
        .reset     (Reset),
        .hold      (Stall || !pc_in_range),
        .load      (Redirect),
        .load_value(redirect_pc),
        .pc        (pc)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state            <= RUN;
            IFID_Instruction <= NOP;
            IFID_PC_plus4    <= 32'd0;
            IFID_Valid       <= 1'b0;
        end else if (Redirect) begin
            if (target_in_range) begin
                state <= RUN;
            end
`ifdef DELAY_SLOT_EN
            if (pc_in_range) begin
                IFID_Instruction <= Instruction;
                IFID_PC_plus4    <= pc_plus4;
                IFID_Valid       <= 1'b1;
            end else begin
                IFID_Instruction <= NOP;
                IFID_PC_plus4    <= 32'd0;
                IFID_Valid       <= 1'b0;
            end
`else
            IFID_Instruction <= NOP;
            IFID_PC_plus4    <= 32'd0;
            IFID_Valid       <= 1'b0;
`endif
        end else if (Stall) begin
            state <= state;
        end else if (!pc_in_range) begin
            state            <= HALT;
            IFID_Instruction <= NOP;
            IFID_PC_plus4    <= 32'd0;
            IFID_Valid       <= 1'b0;
        end else begin
            state            <= RUN;
            IFID_Instruction <= Instruction;
            IFID_PC_plus4    <= pc_plus4;
            IFID_Valid       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// stall/redirect/reset traffic against a behavioural fetch model.
module tb_instruction_fetch;

    logic        Clk;
    logic        Reset;
    logic [31:0] Read_address;
    logic [31:0] Instruction;
    logic        Stall;
    logic        Redirect;
    logic [31:0] Redirect_target;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PC_plus4;
    logic        IFID_Valid;
    logic        Halted;

    logic [31:0] mem [32];

    int checks   = 0;
    int failures = 0;

    // Reference model state: byte PC and the IF/ID triple.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;

    instruction_fetch dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Read_address    (Read_address),
        .Instruction     (Instruction),
        .Stall           (Stall),
        .Redirect        (Redirect),
        .Redirect_target (Redirect_target),
        .IFID_Instruction(IFID_Instruction),
        .IFID_PC_plus4   (IFID_PC_plus4),
        .IFID_Valid      (IFID_Valid),
        .Halted          (Halted)
    );

    assign Instruction = (Read_address < 32'd32) ? mem[Read_address[4:0]] : 32'hBAD0_BAD0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one cycle of inputs (from a falling edge), advance the model at
    // the rising edge and return at the next falling edge.
    task automatic step(input logic rst, input logic stl, input logic rdr, input logic [31:0] tgt);
        logic in_range;
        Reset           = rst;
        Stall           = stl;
        Redirect        = rdr;
        Redirect_target = tgt;
        @(posedge Clk);
        in_range = (m_pc / 4) < 32;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (rdr) begin
`ifdef DELAY_SLOT_EN
            if (in_range) begin
                m_instr = mem[m_pc / 4]; m_pc4 = m_pc + 4; m_valid = 1'b1;
            end else begin
                m_instr = 32'h0; m_valid = 1'b0;
            end
`else
            m_instr = 32'h0; m_valid = 1'b0;
`endif
            m_pc = tgt - (tgt % 4);
        end else if (stl) begin
            m_pc = m_pc;
        end else if (!in_range) begin
            m_instr = 32'h0; m_valid = 1'b0;
        end else begin
            m_instr = mem[m_pc / 4]; m_pc4 = m_pc + 4; m_valid = 1'b1;
            m_pc = m_pc + 4;
        end
        @(negedge Clk);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 32'h40);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (Read_address !== 32'd0) begin failures++; $display("[TB] FAIL reset_ra actual=%0h expected=0", Read_address); end
        checks++; if (IFID_Instruction !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr actual=%0h expected=0", IFID_Instruction); end
        checks++; if (IFID_PC_plus4 !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc4 actual=%0h expected=0", IFID_PC_plus4); end
        checks++; if (IFID_Valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid actual=%0b expected=0", IFID_Valid); end
        checks++; if (Halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted actual=%0b expected=0", Halted); end
    endtask

    task automatic test_advance();
        logic [31:0] words [4];
        words = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            checks++; if (Read_address !== 32'(i + 1)) begin failures++; $display("[TB] FAIL advance_ra actual=%0d expected=%0d", Read_address, i + 1); end
            checks++; if (IFID_Instruction !== words[i]) begin failures++; $display("[TB] FAIL advance_instr actual=%0h expected=%0h", IFID_Instruction, words[i]); end
            checks++; if (IFID_PC_plus4 !== 32'(4 * (i + 1))) begin failures++; $display("[TB] FAIL advance_pc4 actual=%0h expected=%0h", IFID_PC_plus4, 4 * (i + 1)); end
            checks++; if (IFID_Valid !== 1'b1) begin failures++; $display("[TB] FAIL advance_valid actual=%0b expected=1", IFID_Valid); end
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            checks++; if (Read_address !== 32'd2) begin failures++; $display("[TB] FAIL stall_ra actual=%0d expected=2", Read_address); end
            checks++; if (IFID_Instruction !== 32'h22 || IFID_PC_plus4 !== 32'd8 || IFID_Valid !== 1'b1) begin
                failures++; $display("[TB] FAIL stall_ifid actual=%0h/%0h/%0b expected=22/8/1", IFID_Instruction, IFID_PC_plus4, IFID_Valid);
            end
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (IFID_Instruction !== 32'h33 || IFID_PC_plus4 !== 32'd12) begin
            failures++; $display("[TB] FAIL stall_release actual=%0h/%0h expected=33/c", IFID_Instruction, IFID_PC_plus4);
        end
    endtask

    task automatic test_redirect();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h14);
        checks++; if (Read_address !== 32'd5) begin failures++; $display("[TB] FAIL redirect_ra actual=%0d expected=5", Read_address); end
`ifdef DELAY_SLOT_EN
        checks++; if (IFID_Instruction !== 32'h33 || IFID_Valid !== 1'b1) begin
            failures++; $display("[TB] FAIL redirect_slot actual=%0h/%0b expected=33/1", IFID_Instruction, IFID_Valid);
        end
`else
        checks++; if (IFID_Instruction !== 32'h0 || IFID_Valid !== 1'b0) begin
            failures++; $display("[TB] FAIL redirect_bubble actual=%0h/%0b expected=0/0", IFID_Instruction, IFID_Valid);
        end
`endif
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (IFID_Instruction !== mem[5] || IFID_PC_plus4 !== 32'h18 || IFID_Valid !== 1'b1) begin
            failures++; $display("[TB] FAIL redirect_target actual=%0h/%0h/%0b expected=%0h/18/1", IFID_Instruction, IFID_PC_plus4, IFID_Valid, mem[5]);
        end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] tgt;
        tgt = 32'($urandom_range(0, 31)) << 2;
        step(1'b0, 1'b1, 1'b1, tgt | 32'($urandom_range(0, 3)));
        checks++; if (Read_address !== tgt >> 2) begin failures++; $display("[TB] FAIL stall_redirect_ra actual=%0d expected=%0d", Read_address, tgt >> 2); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (IFID_Instruction !== mem[tgt >> 2] || IFID_Valid !== 1'b1) begin
            failures++; $display("[TB] FAIL stall_redirect_fetch actual=%0h/%0b expected=%0h/1", IFID_Instruction, IFID_Valid, mem[tgt >> 2]);
        end
    endtask

    task automatic test_halt();
        step(1'b0, 1'b0, 1'b1, 32'h78);
        checks++; if (Read_address !== 32'd30 || Halted !== 1'b0) begin failures++; $display("[TB] FAIL halt_start actual=%0d/%0b expected=30/0", Read_address, Halted); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (IFID_Instruction !== mem[30] || Halted !== 1'b0) begin failures++; $display("[TB] FAIL halt_word30 actual=%0h/%0b expected=%0h/0", IFID_Instruction, Halted, mem[30]); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (IFID_Instruction !== mem[31] || Read_address !== 32'd32 || Halted !== 1'b1) begin
            failures++; $display("[TB] FAIL halt_word31 actual=%0h/%0d/%0b expected=%0h/32/1", IFID_Instruction, Read_address, Halted, mem[31]);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 || Halted !== 1'b1 || Read_address !== 32'd32) begin
            failures++; $display("[TB] FAIL halt_bubble actual=%0h/%0b/%0b/%0d expected=0/0/1/32", IFID_Instruction, IFID_Valid, Halted, Read_address);
        end
        step(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (Halted !== 1'b1 || Read_address !== 32'd32) begin failures++; $display("[TB] FAIL halt_hold actual=%0b/%0d expected=1/32", Halted, Read_address); end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        checks++; if (Halted !== 1'b0 || Read_address !== 32'd0) begin failures++; $display("[TB] FAIL halt_exit actual=%0b/%0d expected=0/0", Halted, Read_address); end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (IFID_Instruction !== 32'h11 || IFID_Valid !== 1'b1) begin failures++; $display("[TB] FAIL halt_refetch actual=%0h/%0b expected=11/1", IFID_Instruction, IFID_Valid); end
    endtask

    task automatic test_reset_in_halt();
        step(1'b0, 1'b0, 1'b1, 32'h7C);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        checks++; if (Halted !== 1'b1) begin failures++; $display("[TB] FAIL rst_halt_pre actual=%0b expected=1", Halted); end
        step(1'b1, 1'b0, 1'b1, 32'h10);
        checks++; if (Read_address !== 32'd0 || Halted !== 1'b0) begin failures++; $display("[TB] FAIL rst_halt_pc actual=%0d/%0b expected=0/0", Read_address, Halted); end
        checks++; if (IFID_Instruction !== 32'h0 || IFID_PC_plus4 !== 32'h0 || IFID_Valid !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_halt_ifid actual=%0h/%0h/%0b expected=0/0/0", IFID_Instruction, IFID_PC_plus4, IFID_Valid);
        end
    endtask

    task automatic test_random();
        logic rst, stl, rdr;
        logic [31:0] tgt;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 3);
            stl = ($urandom_range(0, 99) < 25);
            rdr = ($urandom_range(0, 99) < 15);
            tgt = (32'($urandom_range(0, 35)) << 2) | 32'($urandom_range(0, 3));
            step(rst, stl, rdr, tgt);
            checks++; if (Read_address !== m_pc / 4) begin failures++; $display("[TB] FAIL rand_ra cycle=%0d actual=%0h expected=%0h", i, Read_address, m_pc / 4); end
            checks++; if (Halted !== ((m_pc / 4) >= 32)) begin failures++; $display("[TB] FAIL rand_halted cycle=%0d actual=%0b expected=%0b", i, Halted, (m_pc / 4) >= 32); end
            checks++; if (IFID_Valid !== m_valid || IFID_Instruction !== m_instr) begin
                failures++; $display("[TB] FAIL rand_ifid cycle=%0d actual=%0h/%0b expected=%0h/%0b", i, IFID_Instruction, IFID_Valid, m_instr, m_valid);
            end
            if (m_valid) begin
                checks++; if (IFID_PC_plus4 !== m_pc4) begin failures++; $display("[TB] FAIL rand_pc4 cycle=%0d actual=%0h expected=%0h", i, IFID_PC_plus4, m_pc4); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        Reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; Redirect_target = 32'h0;
        @(negedge Clk);
        test_reset();
        test_advance();
        test_stall();
        test_redirect();
        test_stall_redirect();
        test_halt();
        test_reset_in_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the MIPS pipeline: owns the program counter, drives the word address into the instruction memory and captures the returned word into the IF/ID pipeline register. It handles stalls, branch/jump redirects and running off the end of the program. It is the initiator side of the instruction memory interface. The memory itself is a combinational read indexed by word address.

## Interface
- RESET_PC, 32'h0000_0000: byte address loaded into the PC on reset.
- MEM_DEPTH, 32: instruction memory size in 32-bit words; valid word indices are 0..MEM_DEPTH-1.

Ports:
- Clk  in  1  single clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Read_address  out  32  word index to instruction memory, = PC[31:2].
- Instruction  in  32  word returned by instruction memory, valid in the same cycle as Read_address.
- Stall  in  1  hold PC and IF/ID (hazard unit).
- Redirect  in  1  taken branch or jump; load Redirect_target.
- Redirect_target  in  32  byte address of the new PC.
- IFID_Instruction  out  32  latched instruction.
- IFID_PC_plus4  out  32  PC+4 of the latched instruction.
- IFID_Valid  out  1  IF/ID holds a real instruction.
- Halted  out  1  fetch stopped, PC out of range.

## Operation
- PC is a 32-bit byte address, increment +4, wraps modulo 2^32. Redirect_target[1:0] is ignored: the PC loads {target[31:2],2'b00}.
- FSM states are RUN and HALT.
- RUN -> HALT when the PC word index >= MEM_DEPTH and Redirect=0. While in HALT:
  - the PC holds;
  - IF/ID loads NOP (32'h0) with Valid=0 each non-stalled cycle;
  - Halted=1.
- HALT -> RUN only on Redirect to an in-range target, or on Reset.
- Per-cycle priority: Reset > Redirect > Stall > advance.
  - Advance: PC <= PC+4; IF/ID <= {Instruction, PC+4, 1}.
  - Stall (no Redirect): PC and all IF/ID outputs hold.
  - Redirect: PC <= target. IF/ID gets a bubble (NOP, Valid=0) unless DELAY_SLOT_EN is defined. Redirect overrides a simultaneous Stall.
- An out-of-range PC never registers Instruction as valid: the fetch slot becomes a bubble.

## Timing
- Reset values:
  - PC = RESET_PC, so Read_address = RESET_PC>>2
  - IFID_Instruction = 0
  - IFID_PC_plus4 = 0
  - IFID_Valid = 0
  - Halted = 0
  - state = RUN
- Read_address is combinational from the PC. The instruction at PC appears on IFID_* one cycle later: latency 1.
- Redirect sampled in cycle n: Read_address = target>>2 in cycle n+1; the target instruction is on IFID in cycle n+2.
- Halted rises in the cycle in which the PC first holds an out-of-range value. It is combinational from state/PC, so no extra cycle.
- Reset asserted mid-stall or mid-redirect wins outright. The next cycle shows reset values.

## Configuration
- DELAY_SLOT_EN defined: MIPS branch delay slot. On Redirect without halt, IF/ID captures the word fetched this cycle as valid (the delay-slot instruction), and the PC loads the target.
- DELAY_SLOT_EN not defined: Redirect flushes. IF/ID loads NOP with Valid=0.

## Structure
- The shared package mips_pkg holds:
  - the NOP constant 32'h0000_0000;
  - the fetch state typedef {RUN, HALT};
  - the default RESET_PC and MEM_DEPTH constants.
- One natural sub-module is pc_reg: the PC register with reset, hold, load and increment. Next-state select stays in instruction_fetch.

## Test plan
- Reset, then 4 free-running cycles with memory words 0..3 = 0x11,0x22,0x33,0x44 -> Read_address 0,1,2,3. IFID_Instruction 0x11,0x22,0x33 with PC_plus4 4,8,12 and Valid=1 from cycle 1.
- Stall held 3 cycles at PC=8 -> Read_address stays 2 and IF/ID unchanged. Release -> next IFID_Instruction = word 2.
- Redirect to 0x14 at PC=8, without the macro -> IF/ID NOP with Valid=0, Read_address=5, word 5 on IF/ID two cycles after the redirect.
  - With DELAY_SLOT_EN: word 2 is captured with Valid=1 instead of the bubble.
- Stall and Redirect together -> Redirect taken (PC=target), stall ignored.
- Run from PC=0x78 with MEM_DEPTH=32 -> word 30, then word 31, then Halted=1 at PC=0x80 with Valid=0. Redirect to 0x0 -> Halted=0, word 0 fetched.
- Assert Reset during HALT with Redirect=1 -> PC=RESET_PC, all outputs at reset values next cycle.
